micro_sequencer: RTL and testbench

Parametrised microprogram sequencer that replaces the fixed-decode control address register in the microprogrammed control unit. Each clock it computes the next control-store address from a sequencing opcode supplied by the current microinstruction. The opcodes are hold, increment, dispatch, branch, conditional branch, call, return, and return-to-fetch. Dispatch goes through a run-time-writable opcode map instead of a hard-coded case table, and a bounded micro-call stack lets microroutines be shared.

---
 rtl/micro_sequencer_if.sv | 36 +++
 rtl/micro_sequencer.sv | 170 +++++++++++++++++
 tb/tb_micro_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: sequencing-control bundle between the microinstruction
// register/datapath (master) and the micro-sequencer (slave).
interface micro_sequencer_if #(
    parameter int ADDR_W      = 8,
    parameter int OP_W        = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic [2:0]        seq_op;
    logic [ADDR_W-1:0] branch_target;
    logic [1:0]        cond_sel;
    logic [3:0]        cond_flags;
    logic [OP_W-1:0]   ir_opcode;
    logic              stall;
    logic              map_we;
    logic [OP_W-1:0]   map_addr;
    logic [ADDR_W-1:0] map_data;
    logic              err_clr;
    logic [ADDR_W-1:0] car_data;
    logic [LVL_W-1:0]  stack_level;
    logic              err_overflow;
    logic              err_underflow;

    modport master (
        output seq_op, branch_target, cond_sel, cond_flags, ir_opcode,
               stall, map_we, map_addr, map_data, err_clr,
        input  car_data, stack_level, err_overflow, err_underflow
    );

    modport slave (
        input  seq_op, branch_target, cond_sel, cond_flags, ir_opcode,
               stall, map_we, map_addr, map_data, err_clr,
        output car_data, stack_level, err_overflow, err_underflow
    );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: computes the next control-store address each clock from the
// sequencing opcode of the current microinstruction. Dispatch uses a writable
// opcode map; an optional bounded micro-call stack is enabled by defining
// MICRO_SEQ_STACK_EN (otherwise call acts as branch and return as
// return-to-fetch, with stack_level and error flags tied low).
module micro_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int OP_W        = 8,
    parameter int STACK_DEPTH = 4,
    parameter int FETCH_ADDR  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    micro_sequencer_if.slave bus
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int MAP_N = 1 << OP_W;
    localparam logic [ADDR_W-1:0] FETCH_A = ADDR_W'(FETCH_ADDR);

    typedef enum logic [2:0] {
        OP_HOLD     = 3'b000,
        OP_DISPATCH = 3'b001,
        OP_INC      = 3'b010,
        OP_FETCH    = 3'b011,
        OP_CBRANCH  = 3'b100,
        OP_CALL     = 3'b101,
        OP_RET      = 3'b110,
        OP_BRANCH   = 3'b111
    } seq_op_e;

    logic [ADDR_W-1:0] r_car;
    logic [ADDR_W-1:0] r_map [MAP_N];
    logic [ADDR_W-1:0] w_next_car;
    logic [ADDR_W-1:0] w_inc;
    logic              w_cond;
    seq_op_e           w_op;

    assign w_op   = seq_op_e'(bus.seq_op);
    assign w_inc  = r_car + ADDR_W'(1);
    assign w_cond = bus.cond_flags[bus.cond_sel];

`ifdef MICRO_SEQ_STACK_EN
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
    logic [LVL_W-1:0]  r_level;
    logic              r_ovf;
    logic              r_unf;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_set_ovf;
    logic              w_set_unf;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_top_idx;

    assign w_full     = (r_level == LVL_W'(STACK_DEPTH));
    assign w_empty    = (r_level == '0);
    assign w_push_idx = IDX_W'(r_level);
    assign w_top_idx  = IDX_W'(r_level - LVL_W'(1));
`endif

    // Next-address selection; stack push/pop and error requests decided alongside.
    always_comb begin
        w_next_car = r_car;
`ifdef MICRO_SEQ_STACK_EN
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_set_ovf  = 1'b0;
        w_set_unf  = 1'b0;
`endif
        case (w_op)
            OP_HOLD:     w_next_car = r_car;
            OP_DISPATCH: w_next_car = r_map[bus.ir_opcode];
            OP_INC:      w_next_car = w_inc;
            OP_FETCH:    w_next_car = FETCH_A;
            OP_CBRANCH:  w_next_car = w_cond ? bus.branch_target : w_inc;
            OP_BRANCH:   w_next_car = bus.branch_target;
`ifdef MICRO_SEQ_STACK_EN
            OP_CALL: begin
                if (w_full) begin
                    w_next_car = FETCH_A;
                    w_set_ovf  = 1'b1;
                end else begin
                    w_next_car = bus.branch_target;
                    w_push     = 1'b1;
                end
            end
            OP_RET: begin
                if (w_empty) begin
                    w_next_car = FETCH_A;
                    w_set_unf  = 1'b1;
                end else begin
                    w_next_car = r_stack[w_top_idx];
                    w_pop      = 1'b1;
                end
            end
`else
            OP_CALL:     w_next_car = bus.branch_target;
            OP_RET:      w_next_car = FETCH_A;
`endif
            default:     w_next_car = r_car;
        endcase
    end

    // Control address register; frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_car <= FETCH_A;
        end else if (!bus.stall) begin
            r_car <= w_next_car;
        end
    end

    // Opcode map: every entry falls back to fetch on reset; writes ignore stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAP_N; i++) begin
                r_map[i] <= FETCH_A;
            end
        end else if (bus.map_we) begin
            r_map[bus.map_addr] <= bus.map_data;
        end
    end

`ifdef MICRO_SEQ_STACK_EN
    // Call stack and sticky errors; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (!bus.stall) begin
            if (w_push) begin
                r_stack[w_push_idx] <= w_inc;
                r_level             <= r_level + LVL_W'(1);
            end else if (w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
            if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end else if (bus.err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_set_unf) begin
                r_unf <= 1'b1;
            end else if (bus.err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign bus.stack_level   = r_level;
    assign bus.err_overflow  = r_ovf;
    assign bus.err_underflow = r_unf;
`else
    logic w_unused_clr;
    assign w_unused_clr      = bus.err_clr;
    assign bus.stack_level   = '0;
    assign bus.err_overflow  = 1'b0;
    assign bus.err_underflow = 1'b0;
`endif

    assign bus.car_data = r_car;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: table-driven vectors fed through an expected-result queue,
// plus hand-written reset checks. Expectations adapt to MICRO_SEQ_STACK_EN.
module tb_micro_sequencer;

`ifdef MICRO_SEQ_STACK_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    localparam logic [2:0] HOLD = 3'b000, DISP = 3'b001, INC = 3'b010, FETCH = 3'b011,
                           CBR  = 3'b100, CALL = 3'b101, RET = 3'b110, BR    = 3'b111;

    typedef struct {
        logic [2:0] op;
        logic [7:0] target;
        logic [1:0] csel;
        logic [3:0] flags;
        logic [7:0] ir;
        logic       stall;
        logic       we;
        logic [7:0] maddr;
        logic [7:0] mdata;
        logic       clr;
        logic [7:0] expCar;
        logic [2:0] expLvl;
        logic       expOvf;
        logic       expUnf;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] car;
        logic [2:0] lvl;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   passCount = 0;
    int   checkCount = 0;
    vec_t vecs[$];
    exp_t expQ[$];

    micro_sequencer_if #(.ADDR_W(8), .OP_W(8), .STACK_DEPTH(4)) busIf ();

    micro_sequencer #(.ADDR_W(8), .OP_W(8), .STACK_DEPTH(4), .FETCH_ADDR(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] lvl(input int n);
        return SE ? 3'(n) : 3'd0;
    endfunction

    task automatic check(input string name, input int id, input int act, input int exp);
        checkCount++;
        if (act == exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", name, id, act, exp);
        end
    endtask

    task automatic addVec(input logic [2:0] op, input logic [7:0] target, input logic [1:0] csel,
                          input logic [3:0] flags, input logic [7:0] ir, input logic stall,
                          input logic we, input logic [7:0] maddr, input logic [7:0] mdata,
                          input logic clr, input logic [7:0] expCar, input logic [2:0] expLvl,
                          input logic expOvf, input logic expUnf);
        vec_t v;
        v.op = op; v.target = target; v.csel = csel; v.flags = flags; v.ir = ir;
        v.stall = stall; v.we = we; v.maddr = maddr; v.mdata = mdata; v.clr = clr;
        v.expCar = expCar; v.expLvl = expLvl; v.expOvf = expOvf; v.expUnf = expUnf;
        vecs.push_back(v);
    endtask

    task automatic driveIdle();
        busIf.seq_op = HOLD; busIf.branch_target = '0; busIf.cond_sel = '0;
        busIf.cond_flags = '0; busIf.ir_opcode = '0; busIf.stall = 1'b0;
        busIf.map_we = 1'b0; busIf.map_addr = '0; busIf.map_data = '0; busIf.err_clr = 1'b0;
    endtask

    // Drive one vector between edges and queue its expected result.
    task automatic applyStimulus(input vec_t v, input int id);
        exp_t e;
        @(negedge clk);
        busIf.seq_op = v.op; busIf.branch_target = v.target; busIf.cond_sel = v.csel;
        busIf.cond_flags = v.flags; busIf.ir_opcode = v.ir; busIf.stall = v.stall;
        busIf.map_we = v.we; busIf.map_addr = v.maddr; busIf.map_data = v.mdata;
        busIf.err_clr = v.clr;
        e.id = id; e.car = v.expCar; e.lvl = v.expLvl; e.ovf = v.expOvf; e.unf = v.expUnf;
        expQ.push_back(e);
    endtask

    // Wait past the edge, pop the oldest expectation and compare.
    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        checkCount++;
        if (expQ.size() == 0) begin
            $display("[TB] FAIL scoreboard: got empty queue, expected a pending result");
        end else begin
            passCount++;
            e = expQ.pop_front();
            check("car_data", e.id, int'(busIf.car_data), int'(e.car));
            check("stack_level", e.id, int'(busIf.stack_level), int'(e.lvl));
            check("err_overflow", e.id, int'(busIf.err_overflow), int'(e.ovf));
            check("err_underflow", e.id, int'(busIf.err_underflow), int'(e.unf));
        end
    endtask

    task automatic runVec(input vec_t v, input int id);
        applyStimulus(v, id);
        checkOutput();
    endtask

    task automatic step(input logic [2:0] op, input logic [7:0] target, input logic [7:0] ir,
                        input logic [7:0] expCar, input logic [2:0] expLvl,
                        input logic expOvf, input logic expUnf, input int id);
        vec_t v;
        v.op = op; v.target = target; v.csel = 2'd0; v.flags = 4'd0; v.ir = ir;
        v.stall = 1'b0; v.we = 1'b0; v.maddr = '0; v.mdata = '0; v.clr = 1'b0;
        v.expCar = expCar; v.expLvl = expLvl; v.expOvf = expOvf; v.expUnf = expUnf;
        runVec(v, id);
    endtask

    initial begin
        //     op    tgt    cs  flg    ir     st we  ma     md     clr  car              lvl      ovf  unf
        addVec(HOLD, 8'h00, 0, 4'h0, 8'h00, 0, 1, 8'h03, 8'h0B, 0, 8'h00,           lvl(0), 0,   0);
        addVec(DISP, 8'h00, 0, 4'h0, 8'h03, 0, 0, 8'h00, 8'h00, 0, 8'h0B,           lvl(0), 0,   0);
        addVec(DISP, 8'h00, 0, 4'h0, 8'h05, 0, 0, 8'h00, 8'h00, 0, 8'h00,           lvl(0), 0,   0);
        addVec(BR,   8'hFF, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'hFF,           lvl(0), 0,   0);
        addVec(INC,  8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00,           lvl(0), 0,   0);
        addVec(CBR,  8'h11, 0, 4'h1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h11,           lvl(0), 0,   0);
        addVec(CBR,  8'h11, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h12,           lvl(0), 0,   0);
        addVec(CBR,  8'h55, 2, 4'h4, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h55,           lvl(0), 0,   0);
        addVec(CBR,  8'h99, 3, 4'h7, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h56,           lvl(0), 0,   0);
        addVec(BR,   8'h10, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h10,           lvl(0), 0,   0);
        addVec(CALL, 8'h20, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h20,           lvl(1), 0,   0);
        addVec(INC,  8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h21,           lvl(1), 0,   0);
        addVec(CALL, 8'h30, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h30,           lvl(2), 0,   0);
        addVec(INC,  8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h31,           lvl(2), 0,   0);
        addVec(CALL, 8'h40, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h40,           lvl(3), 0,   0);
        addVec(INC,  8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h41,           lvl(3), 0,   0);
        addVec(CALL, 8'h50, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h50,           lvl(4), 0,   0);
        addVec(CALL, 8'h60, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, SE ? 8'h00 : 8'h60, lvl(4), SE, 0);
        addVec(RET,  8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, SE ? 8'h42 : 8'h00, lvl(3), SE, 0);
        addVec(RET,  8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, SE ? 8'h32 : 8'h00, lvl(2), SE, 0);
        addVec(RET,  8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, SE ? 8'h22 : 8'h00, lvl(1), SE, 0);
        addVec(RET,  8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, SE ? 8'h11 : 8'h00, lvl(0), SE, 0);
        addVec(RET,  8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00,           lvl(0), SE,  SE);
        addVec(HOLD, 8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h00,           lvl(0), 0,   0);
        addVec(RET,  8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h00,           lvl(0), 0,   SE);
        addVec(HOLD, 8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h00,           lvl(0), 0,   0);
        addVec(BR,   8'h80, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h80,           lvl(0), 0,   0);
        addVec(INC,  8'h00, 0, 4'h0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 8'h80,           lvl(0), 0,   0);
        addVec(INC,  8'h00, 0, 4'h0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 8'h80,           lvl(0), 0,   0);
        addVec(INC,  8'h00, 0, 4'h0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 8'h80,           lvl(0), 0,   0);
        addVec(CALL, 8'h90, 0, 4'h0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 8'h80,           lvl(0), 0,   0);
        addVec(HOLD, 8'h00, 0, 4'h0, 8'h00, 1, 1, 8'h09, 8'h44, 0, 8'h80,           lvl(0), 0,   0);
        addVec(DISP, 8'h00, 0, 4'h0, 8'h07, 0, 1, 8'h07, 8'h33, 0, 8'h00,           lvl(0), 0,   0);
        addVec(DISP, 8'h00, 0, 4'h0, 8'h07, 0, 0, 8'h00, 8'h00, 0, 8'h33,           lvl(0), 0,   0);
        addVec(DISP, 8'h00, 0, 4'h0, 8'h09, 0, 0, 8'h00, 8'h00, 0, 8'h44,           lvl(0), 0,   0);
        addVec(FETCH,8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00,           lvl(0), 0,   0);
        addVec(RET,  8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00,           lvl(0), 0,   SE);
        addVec(HOLD, 8'h00, 0, 4'h0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 8'h00,           lvl(0), 0,   SE);
        addVec(HOLD, 8'h00, 0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h00,           lvl(0), 0,   0);

        driveIdle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset car_data", -1, int'(busIf.car_data), 0);
        check("reset stack_level", -1, int'(busIf.stack_level), 0);
        check("reset err_overflow", -1, int'(busIf.err_overflow), 0);
        check("reset err_underflow", -1, int'(busIf.err_underflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            runVec(vecs[i], i);
        end

        // Reset mid-routine: two calls deep, then an asynchronous reset between edges.
        step(BR,   8'h10, 8'h00, 8'h10, lvl(0), 0, 0, 100);
        step(CALL, 8'h20, 8'h00, 8'h20, lvl(1), 0, 0, 101);
        step(INC,  8'h00, 8'h00, 8'h21, lvl(1), 0, 0, 102);
        step(CALL, 8'h30, 8'h00, 8'h30, lvl(2), 0, 0, 103);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset car_data", 104, int'(busIf.car_data), 0);
        check("async reset stack_level", 104, int'(busIf.stack_level), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(DISP, 8'h00, 8'h03, 8'h00, lvl(0), 0, 0, 105);
        step(DISP, 8'h00, 8'h07, 8'h00, lvl(0), 0, 0, 106);
        step(RET,  8'h00, 8'h00, 8'h00, lvl(0), 0, SE, 107);

        check("scoreboard drained", 108, expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
